// File: rtl/axi_lite_arbiter_if.sv
// AXI-lite bundle shared by the arbiter, its requesters and the hub.
// Mw/Mr flow master->slave, Sw/Sr flow slave->master.
interface AXI_ift #(
    parameter int AW = 64,
    parameter int DW = 64
);
    typedef struct packed {
        logic [AW-1:0]   awaddr;
        logic [2:0]      awprot;
        logic            awvalid;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wstrb;
        logic            wvalid;
        logic            bready;
    } mw_t;

    typedef struct packed {
        logic [AW-1:0] araddr;
        logic [2:0]    arprot;
        logic          arvalid;
        logic          rready;
    } mr_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic [1:0] bresp;
        logic       bvalid;
    } sw_t;

    typedef struct packed {
        logic          arready;
        logic [DW-1:0] rdata;
        logic [1:0]    rresp;
        logic          rvalid;
    } sr_t;

    mw_t Mw;
    mr_t Mr;
    sw_t Sw;
    sr_t Sr;

    modport Master (output Mw, Mr, input Sw, Sr);
    modport Slave  (input Mw, Mr, output Sw, Sr);
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-lite arbiter in front of the hub master port.
// Read and write channels each own a grant FSM and a watchdog.
module axi_lite_arbiter_chan #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       slv_valid_i,
    input  logic       gnt_ready_i,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic       err_o,
    output logic       timeout_o
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CMAX =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // last_q set means m1 was served last, so m0 wins the next tie
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    if (&req_i)
                        grant_d = (ROUND_ROBIN != 0 && !last_q) ? 2'b10 : 2'b01;
                    else
                        grant_d = req_i;
                end
            end
            BUSY: begin
                if (slv_valid_i && gnt_ready_i) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CMAX) begin
                    state_d = ERR;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                if (gnt_ready_i) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o   = grant_q;
    assign busy_o    = (state_q == BUSY);
    assign err_o     = (state_q == ERR);
    assign timeout_o = to_q;
endmodule

module axi_lite_arbiter #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic       clk,
    input  logic       rstn,
    AXI_ift.Slave      master0,
    AXI_ift.Slave      master1,
    AXI_ift.Master     slave,
    output logic [1:0] rd_grant,
    output logic [1:0] wr_grant,
    output logic       rd_timeout,
    output logic       wr_timeout
);
    logic rd_busy, rd_err, rd_rdy;
    logic wr_busy, wr_err, wr_rdy;

    assign rd_rdy = (rd_grant[0] & master0.Mr.rready) |
                    (rd_grant[1] & master1.Mr.rready);
    assign wr_rdy = (wr_grant[0] & master0.Mw.bready) |
                    (wr_grant[1] & master1.Mw.bready);

    axi_lite_arbiter_chan #(
        .ROUND_ROBIN    (ROUND_ROBIN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       ({master1.Mr.arvalid, master0.Mr.arvalid}),
        .slv_valid_i (slave.Sr.rvalid),
        .gnt_ready_i (rd_rdy),
        .grant_o     (rd_grant),
        .busy_o      (rd_busy),
        .err_o       (rd_err),
        .timeout_o   (rd_timeout)
    );

    axi_lite_arbiter_chan #(
        .ROUND_ROBIN    (ROUND_ROBIN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       ({master1.Mw.awvalid, master0.Mw.awvalid}),
        .slv_valid_i (slave.Sw.bvalid),
        .gnt_ready_i (wr_rdy),
        .grant_o     (wr_grant),
        .busy_o      (wr_busy),
        .err_o       (wr_err),
        .timeout_o   (wr_timeout)
    );

    // Hung reads end with a DECERR carrying zero data
    always_comb begin
        slave.Mr   = '0;
        master0.Sr = '0;
        master1.Sr = '0;
        if (rd_busy && rd_grant[0]) begin
            slave.Mr   = master0.Mr;
            master0.Sr = slave.Sr;
        end else if (rd_busy && rd_grant[1]) begin
            slave.Mr   = master1.Mr;
            master1.Sr = slave.Sr;
        end else if (rd_err && rd_grant[0]) begin
            master0.Sr.arready = 1'b1;
            master0.Sr.rvalid  = 1'b1;
            master0.Sr.rdata   = {AXI_DATA_WIDTH{1'b0}};
            master0.Sr.rresp   = 2'b11;
        end else if (rd_err && rd_grant[1]) begin
            master1.Sr.arready = 1'b1;
            master1.Sr.rvalid  = 1'b1;
            master1.Sr.rdata   = {AXI_DATA_WIDTH{1'b0}};
            master1.Sr.rresp   = 2'b11;
        end
    end

    always_comb begin
        slave.Mw   = '0;
        master0.Sw = '0;
        master1.Sw = '0;
        if (wr_busy && wr_grant[0]) begin
            slave.Mw   = master0.Mw;
            master0.Sw = slave.Sw;
        end else if (wr_busy && wr_grant[1]) begin
            slave.Mw   = master1.Mw;
            master1.Sw = slave.Sw;
        end else if (wr_err && wr_grant[0]) begin
            master0.Sw.awready = 1'b1;
            master0.Sw.wready  = 1'b1;
            master0.Sw.bvalid  = 1'b1;
            master0.Sw.bresp   = 2'b11;
        end else if (wr_err && wr_grant[1]) begin
            master1.Sw.awready = 1'b1;
            master1.Sw.wready  = 1'b1;
            master1.Sw.bvalid  = 1'b1;
            master1.Sw.bresp   = 2'b11;
        end
    end

    localparam int ADDR_W_CHECK = AXI_ADDR_WIDTH;
    logic unused_addr_w;
    assign unused_addr_w = (ADDR_W_CHECK == 0);
endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter that sits in front of Axi_lite_Hub's master port.
- Shares the hub between instruction fetch (m0) and data/load-store (m1).
- Read and write channels are arbitrated independently, each with its own grant FSM and timeout watchdog.
- A granted master owns its channel until the response handshake, so the hub's combinational address decode stays stable. A hung transaction (for example a decode miss routed to the hub's dummy slave) is ended with an arbiter-generated DECERR response.

Parameters:
- ROUND_ROBIN, default 1: 1 = rotate priority; 0 = fixed priority, m0 always wins.
- TIMEOUT_CYCLES, default 256: cycles in BUSY before the watchdog fires; 0 disables the watchdog.
- AXI_ADDR_WIDTH, default 64: address width of all AXI_ift instances.
- AXI_DATA_WIDTH, default 64: data width of all AXI_ift instances.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- master0  AXI_ift.Slave  bundle  instruction-fetch requester (Mw/Mr in, Sw/Sr out).
- master1  AXI_ift.Slave  bundle  data requester.
- slave  AXI_ift.Master  bundle  to the Axi_lite_Hub master port.
- rd_grant  output  2  one-hot read owner: bit0 = m0, bit1 = m1; 00 when idle.
- wr_grant  output  2  one-hot write owner, same encoding.
- rd_timeout  output  1  one-cycle pulse when the read watchdog fires.
- wr_timeout  output  1  one-cycle pulse when the write watchdog fires.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: both FSMs go to IDLE; grants = 00; timeout pulses = 0; counters = 0; last_rd and last_wr = m1, so m0 wins the first tie.
- Idle outputs: slave.Mr and slave.Mw are all-zero while the channel is IDLE.
- Non-granted masters: always see all-zero Sr/Sw (ready = 0, valid = 0, data = 0, resp = 0).

Read FSM (states IDLE, BUSY, ERR):
- IDLE: sample arvalid of both masters.
  - One request: register a grant to that master.
  - Both, ROUND_ROBIN=1: grant the master that is not last_rd.
  - Both, ROUND_ROBIN=0: grant m0.
  - Go to BUSY next cycle. Arbitration latency is 1 cycle; nothing reaches the slave in the arbitration cycle.
- BUSY:
  - slave.Mr = granted master's Mr; granted master's Sr = slave.Sr (pass-through, 0 added latency).
  - Leave on the cycle where slave.Sr.rvalid & granted rready: go to IDLE, update last_rd, clear rd_grant next cycle.
  - arvalid is not re-checked in BUSY. Masters must hold araddr and arvalid until the r handshake (codebase rule). The arbiter never revokes a grant early.
- Watchdog:
  - rd_cnt clears on entry to BUSY and increments each BUSY cycle.
  - If TIMEOUT_CYCLES != 0, rd_cnt == TIMEOUT_CYCLES-1 and no r handshake this cycle: go to ERR and pulse rd_timeout.
  - A handshake on that same cycle wins: go to IDLE, no pulse.
- ERR:
  - slave.Mr is all-zero.
  - Granted master sees arready = 1, rvalid = 1, rdata = 0, rresp = 2'b11.
  - Stay until rready, then go to IDLE and update last_rd.
- Write FSM: identical structure.
  - Request is awvalid; completion is slave.Sw.bvalid & granted bready.
  - Pass-through covers aw, w and b.
  - ERR drives awready = 1, wready = 1, bvalid = 1, bresp = 2'b11.
  - Uses wr_cnt and wr_timeout.
- Channel independence: read and write may be granted to different masters, or to the same master, simultaneously.
- Reset mid-transaction: immediate return to IDLE. Slave-side signals drop to zero asynchronously. No response is replayed.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Single read: m0 reads 0x80000000, slave answers 3 cycles after grant. Expect rd_grant = 01 one cycle after arvalid, rdata passed through unchanged, grant = 00 the cycle after the rvalid&rready handshake.
- Tie, round robin: m0 and m1 arvalid together, asserted back-to-back, after reset. Grant order m0, m1, m0; with ROUND_ROBIN=0 the order is m0, m0, m0 while m1 starves.
- Independent channels: m0 reads while m1 writes 0x10000 with wstrb = 0xFF. Both complete concurrently; rd_grant = 01 and wr_grant = 10 in the same cycle.
- Timeout, TIMEOUT_CYCLES = 8: m1 reads unmapped 0x5000 (hub returns nothing). rd_timeout pulses 8 cycles after BUSY entry; m1 gets rresp = 11, rdata = 0; then IDLE.
- Boundary: slave rvalid lands exactly on cycle TIMEOUT_CYCLES-1. Normal completion, no rd_timeout, rresp from the slave.
- Reset mid-write: deassert rstn while BUSY. wr_grant = 00 and slave.Mw all-zero immediately; after release, a pending m0 awvalid is granted cleanly.
